// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// Multiplies with a right-shifting shift-add and divides by restoring division,
// both on operand magnitudes. Signs are fixed up when the result is captured.
// STEPS_PER_CYCLE iterations run per clock, and its legal values are 1, 2 and 4.
// Division by zero and signed overflow skip the iteration and finish in one cycle.

module muldiv_unit #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam int N = 32 / STEPS_PER_CYCLE;
  localparam logic [4:0] LAST_COUNT = 5'(N - 1);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  muldiv_funct3_t req_op;
  muldiv_funct3_t op;

  logic [4:0]  count;
  logic [4:0]  rd_q;
  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [31:0] opnd;
  logic        neg_main;
  logic        neg_rem;

  logic        accept;
  logic        calc_last;

  logic        req_a_signed;
  logic        req_b_signed;
  logic        req_sign_a;
  logic        req_sign_b;
  logic [31:0] req_a_mag;
  logic [31:0] req_b_mag;
  logic        req_div_zero;
  logic        req_overflow;
  logic        req_special;
  logic [31:0] special_result;

  logic [32:0] step_sum;
  logic [32:0] step_shift;
  logic [33:0] step_trial;

  logic [63:0] prod_signed;
  logic [31:0] quo_signed;
  logic [31:0] rem_signed;
  logic [31:0] final_result;

  assign req_op = muldiv_funct3_t'(funct3);

  // Decode the signedness, the magnitudes and the RISC-V special cases of the incoming request
  always_comb begin
    req_a_signed = 1'b0;
    req_b_signed = 1'b0;
    case (req_op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        req_a_signed = 1'b1;
        req_b_signed = 1'b1;
      end
      OP_MULHSU: req_a_signed = 1'b1;
      default: begin
        req_a_signed = 1'b0;
        req_b_signed = 1'b0;
      end
    endcase

    req_sign_a = req_a_signed & rs1_data[31];
    req_sign_b = req_b_signed & rs2_data[31];
    req_a_mag  = req_sign_a ? (~rs1_data + 32'd1) : rs1_data;
    req_b_mag  = req_sign_b ? (~rs2_data + 32'd1) : rs2_data;

    req_div_zero = funct3[2] & (rs2_data == 32'd0);
    req_overflow = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                   (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    req_special  = req_div_zero | req_overflow;

    special_result = 32'd0;
    if (req_div_zero) begin
      special_result = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    end else if (req_overflow) begin
      special_result = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  assign accept    = (state == S_IDLE) && start && !flush;
  assign calc_last = (state == S_CALC) && (count == LAST_COUNT);

  // Advance the shift-add or restoring-divide datapath by STEPS_PER_CYCLE iterations
  always_comb begin
    acc_next   = acc;
    step_sum   = 33'd0;
    step_shift = 33'd0;
    step_trial = 34'd0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (op[2]) begin
        // The upper half holds the partial remainder. The lower half shifts
        // the dividend out and the quotient bits in.
        step_shift = {acc_next[63:32], acc_next[31]};
        step_trial = {1'b0, step_shift} - {2'b00, opnd};
        if (!step_trial[33]) begin
          acc_next = {step_trial[31:0], acc_next[30:0], 1'b1};
        end else begin
          acc_next = {step_shift[31:0], acc_next[30:0], 1'b0};
        end
      end else begin
        // The upper half accumulates the multiplicand. The lower half shifts
        // the multiplier out and the product bits in.
        step_sum = {1'b0, acc_next[63:32]} + (acc_next[0] ? {1'b0, opnd} : 33'd0);
        acc_next = {step_sum, acc_next[31:1]};
      end
    end
  end

  // Form the architectural result from the final datapath state, applying sign correction
  always_comb begin
    prod_signed = neg_main ? (~acc_next + 64'd1) : acc_next;
    quo_signed  = neg_main ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
    rem_signed  = neg_rem ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
    case (op)
      OP_MUL:                       final_result = prod_signed[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_signed[63:32];
      OP_DIV, OP_DIVU:              final_result = quo_signed;
      default:                      final_result = rem_signed;
    endcase
  end

  // Next-state logic: flush overrides every transition
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = req_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (calc_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: latch the request on accept, iterate in CALC, and capture the writeback on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= OP_MUL;
      rd_q     <= 5'd0;
      count    <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= 32'd0;
      rd_out   <= 5'd0;
    end else if (!flush) begin
      if (accept) begin
        op       <= req_op;
        rd_q     <= rd_in;
        count    <= 5'd0;
        neg_main <= req_sign_a ^ req_sign_b;
        neg_rem  <= req_sign_a;
        if (req_special) begin
          result <= special_result;
          rd_out <= rd_in;
        end else if (funct3[2]) begin
          acc  <= {32'd0, req_a_mag};
          opnd <= req_b_mag;
        end else begin
          acc  <= {32'd0, req_b_mag};
          opnd <= req_a_mag;
        end
      end else if (state == S_CALC) begin
        acc   <= acc_next;
        count <= count + 5'd1;
        if (calc_last) begin
          result <= final_result;
          rd_out <= rd_q;
        end
      end
    end
  end

  assign busy = (state != S_IDLE) || accept;
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Three instances with STEPS_PER_CYCLE set to 1, 2 and 4 share the same stimulus.
// Each instance has its own expectation queue and its own monitor.

module tb_muldiv_unit;

  localparam int NI = 3;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] acc_cyc;
    logic [31:0] lat;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        flush    = 1'b0;
  logic [2:0]  funct3   = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_in    = 5'd0;

  logic        busy_w   [NI];
  logic        done_w   [NI];
  logic [31:0] result_w [NI];
  logic [4:0]  rd_w     [NI];

  exp_t exp_q [NI][$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Free-running clock and cycle counter used for latency measurement
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: full-width arithmetic following the RV32M rules
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 32'd0;
    p  = 64'd0;
    case (f)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = 64'(sa / sb); r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = 64'(sa % sb); r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && b == 32'd0) ||
           ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic bit all_idle();
    bit ok;
    ok = 1'b1;
    for (int g = 0; g < NI; g++) begin
      if (busy_w[g] !== 1'b0 || exp_q[g].size() != 0) ok = 1'b0;
    end
    return ok;
  endfunction

  // One instance and one monitor per STEPS_PER_CYCLE value
  for (genvar g = 0; g < NI; g++) begin : inst
    exp_t e;

    muldiv_unit #(.STEPS_PER_CYCLE(1 << g)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_in    (rd_in),
      .flush    (flush),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .result   (result_w[g]),
      .rd_out   (rd_w[g])
    );

    // Monitor: every done pulse pops one expectation and compares result, rd and latency
    always @(negedge clk) begin
      if (done_w[g] === 1'b1) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done[s%0d] actual=done expected=no_done", 1 << g);
        end else begin
          e = exp_q[g].pop_front();
          checkOutput($sformatf("result[s%0d]", 1 << g), result_w[g], e.res);
          checkOutput($sformatf("rd_out[s%0d]", 1 << g), {27'd0, rd_w[g]}, {27'd0, e.rd});
          checkOutput($sformatf("latency[s%0d]", 1 << g), 32'(cyc) - e.acc_cyc + 32'd1, e.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (all_idle()) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout actual=busy expected=idle_within_400_cycles");
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] exp_res, input bit push);
    exp_t ex;
    wait_idle();
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("busy_on_accept[s%0d]", 1 << g), {31'd0, busy_w[g]}, 32'd1);
      if (push) begin
        ex.res     = exp_res;
        ex.rd      = rd;
        ex.acc_cyc = 32'(cyc + 1);
        ex.lat     = is_special(f, a, b) ? 32'd1 : 32'(32 / (1 << g) + 1);
        exp_q[g].push_back(ex);
      end
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    funct3   = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'($urandom);
  endtask

  task automatic check_cleared(input string tag);
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("%s_busy[s%0d]", tag, 1 << g), {31'd0, busy_w[g]}, 32'd0);
      checkOutput($sformatf("%s_done[s%0d]", tag, 1 << g), {31'd0, done_w[g]}, 32'd0);
      checkOutput($sformatf("%s_result[s%0d]", tag, 1 << g), result_w[g], 32'd0);
      checkOutput($sformatf("%s_rd[s%0d]", tag, 1 << g), {27'd0, rd_w[g]}, 32'd0);
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          sel;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1);
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b1);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b1);
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b1);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 1'b1);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        1'b1);
    applyStimulus(3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         1'b1);
    applyStimulus(3'd5, 32'h1234,       32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(3'd7, 32'h1234,       32'd0,         5'd14, 32'h1234,      1'b1);
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1);
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b1);

    $display("[TB] flush mid-calculation");
    applyStimulus(3'd0, 32'h55, 32'h77, 5'd3, 32'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("busy_after_flush[s%0d]", 1 << g), {31'd0, busy_w[g]}, 32'd0);
    end
    repeat (40) @(negedge clk);
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd4, 32'd12, 1'b1);

    $display("[TB] flush and start together");
    wait_idle();
    funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd1;
    start = 1'b1;
    flush = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("busy_flush_start[s%0d]", 1 << g), {31'd0, busy_w[g]}, 32'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("not_accepted[s%0d]", 1 << g), {31'd0, busy_w[g]}, 32'd0);
    end

    $display("[TB] start while busy is ignored");
    applyStimulus(3'd5, 32'd1000, 32'd3, 5'd21, 32'd333, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd5; rd_in = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    $display("[TB] asynchronous reset mid-calculation");
    applyStimulus(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd20, 32'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_cleared("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] randomized operations");
    for (int n = 0; n < 30; n++) begin
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      applyStimulus(f, a, b, rd, ref_model(f, a, b), 1'b1);
    end

    wait_idle();
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("pending[s%0d]", 1 << g), 32'(exp_q[g].size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
